// File: rtl/layer_mem_arbiter.sv
// Three-requester round-robin arbiter (conv, max-pool, flatten) onto a shared layer memory.
// Grant is combinational; bus strobes follow one cycle later, read data returns two cycles after grant.
module layer_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [2:0]    we,
  input  logic [2:0]    lock,
  input  logic [2:0]    sel0,
  input  logic [2:0]    sel1,
  input  logic [2:0]    sel2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  input  logic          halt,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          idle,
  output logic          err,
  output logic [1:0]    err_id,
  output logic          crd,
  output logic          cwr,
  output logic [2:0]    csel,
  output logic [AW-1:0] caddr_rd,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd
);

  typedef struct packed {
    logic          we;
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? v - 3'd3 : v;
    return t[1:0];
  endfunction

  function automatic logic sel_legal(input logic [2:0] s);
    return (s != 3'd0) && (s < 3'd6);
  endfunction

  req_t [2:0] rq;
  assign rq[0] = {we[0], sel0, addr0, wdata0};
  assign rq[1] = {we[1], sel1, addr1, wdata1};
  assign rq[2] = {we[2], sel2, addr2, wdata2};

  logic [1:0] ptr;
  logic       lock_vld;
  logic [1:0] lock_k;

  logic       grant;
  logic       lock_win;
  logic [1:0] win_k;
  logic [1:0] cand;
  req_t       g;
  logic       g_legal;

  // Lock holder (last cycle's grantee still asserting lock) beats the rotating pointer.
  always_comb begin
    grant    = 1'b0;
    lock_win = 1'b0;
    win_k    = 2'd0;
    cand     = 2'd0;
    if (reset && !halt) begin
      if (lock_vld && req[lock_k] && lock[lock_k]) begin
        grant    = 1'b1;
        lock_win = 1'b1;
        win_k    = lock_k;
      end else begin
        for (int i = 0; i < 3; i++) begin
          cand = wrap3({1'b0, ptr} + 3'(i));
          if (!grant && req[cand]) begin
            grant = 1'b1;
            win_k = cand;
          end
        end
      end
    end
  end

  assign gnt     = grant ? (3'b001 << win_k) : 3'b000;
  assign g       = rq[win_k];
  assign g_legal = sel_legal(g.sel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= 2'd0;
      lock_vld <= 1'b0;
      lock_k   <= 2'd0;
    end else begin
      lock_vld <= grant;
      lock_k   <= win_k;
      if (grant && !lock_win) ptr <= wrap3({1'b0, win_k} + 3'd1);
    end
  end

  // Stage 1: memory bus strobes and illegal-select flag.
  logic       rd_pend;
  logic       rd_legal;
  logic [1:0] rd_k;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 3'd0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      err      <= 1'b0;
      err_id   <= 2'd0;
      rd_pend  <= 1'b0;
      rd_legal <= 1'b0;
      rd_k     <= 2'd0;
    end else begin
      crd      <= grant && g_legal && !g.we;
      cwr      <= grant && g_legal && g.we;
      err      <= grant && !g_legal;
      rd_pend  <= grant && !g.we;
      rd_legal <= g_legal;
      rd_k     <= win_k;
      if (grant && g_legal) csel <= g.sel;
      if (grant && g_legal && !g.we) caddr_rd <= g.addr;
      if (grant && g_legal && g.we) begin
        caddr_wr <= g.addr;
        cdata_wr <= g.wdata;
      end
      if (grant && !g_legal) err_id <= win_k;
    end
  end

  // Stage 2: read return; an illegal read still returns, with zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 3'b000;
      rdata  <= '0;
    end else begin
      rvalid <= rd_pend ? (3'b001 << rd_k) : 3'b000;
      if (rd_pend) rdata <= rd_legal ? cdata_rd : '0;
    end
  end

  // Grant history for the last two cycles; idle when neither slot is occupied.
  logic [2:1] vld_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[1], grant};
  end

  assign idle = ~|vld_pipe;

endmodule
